multdiv_shift_reg: RTL

//   Parametrised WIDTH-bit operand/accumulator register for the mult/div datapath.

---
 rtl/multdiv_shift_reg.sv | 78 +++++++
 1 files changed

// File: rtl/multdiv_shift_reg.sv
// multdiv_shift_reg: loadable shift register with autonomous counted shift runs
module multdiv_shift_reg #(
  parameter int WIDTH = 32,
  parameter int SHIFTS = 32,
  localparam int CNT_W = $clog2(SHIFTS + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_en,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic             step,
  input  logic             dir,
  input  logic             arith,
  input  logic             ser_in,
  input  logic             out_en,
  output logic [WIDTH-1:0] out,
  output logic             shift_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q;
  logic             so_q, so_d, done_q, run_dir_q, run_arith_q, sh_dir, sh_arith;
  // A run uses the direction latched at start; a single step uses the live inputs
  always_comb begin
    sh_dir   = (state_q == RUN) ? run_dir_q : dir;
    sh_arith = (state_q == RUN) ? run_arith_q : arith;
    q_d      = sh_dir ? {sh_arith ? q_q[WIDTH-1] : ser_in, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], ser_in};
    so_d     = sh_dir ? q_q[0] : q_q[WIDTH-1];
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      so_q        <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      run_dir_q   <= 1'b0;
      run_arith_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (in_en) begin
        q_q     <= d;
        cnt_q   <= '0;
        state_q <= (state_q == IDLE && start) ? RUN : IDLE;
        if (state_q == IDLE && start) begin
          run_dir_q   <= dir;
          run_arith_q <= arith;
        end
      end else if (state_q == RUN) begin
        q_q   <= q_d;
        so_q  <= so_d;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SHIFTS - 1)) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      end else if (start) begin
        run_dir_q   <= dir;
        run_arith_q <= arith;
        cnt_q       <= '0;
        state_q     <= RUN;
      end else if (step) begin
        q_q  <= q_d;
        so_q <= so_d;
      end
    end
  end
  assign out       = out_en ? q_q : '0;
  assign shift_out = so_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign cnt       = cnt_q;
endmodule
